// File: rtl/pio_arb_pkg.sv
// Shared types and constants for the PIO access arbiter.
// Optional build macro used by the arbiter: PIO_ARB_LOCK_EN (locked RMW sequences).
package pio_arb_pkg;

    // Transaction sequencer states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    // Upper bound on requesters; grant_id is sized to cover it
    localparam int MAX_REQ = 8;
    localparam int GRANT_W = 3;

    // PIO register map (word addresses)
    localparam logic [2:0] PIO_ADDR_DATA     = 3'd0;
    localparam logic [2:0] PIO_ADDR_IRQ_MASK = 3'd2;
    localparam logic [2:0] PIO_ADDR_SET      = 3'd4;
    localparam logic [2:0] PIO_ADDR_CLR      = 3'd5;

endpackage

// File: rtl/pio_arb_rr_pick.sv
// Combinational round-robin picker: the requester following 'last' (wrapping)
// has highest priority, 'last' itself has lowest.
module pio_arb_rr_pick
    import pio_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GRANT_W-1:0] last,
    output logic [GRANT_W-1:0] winner,
    output logic               valid
);

    int best_dist;

    // Choose the requesting index with the smallest rotating distance from last+1
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        winner    = last;
        valid     = |req;
        best_dist = NUM_REQ;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (req[j] && (((j + NUM_REQ - int'(last) - 1) % NUM_REQ) < best_dist)) begin
                best_dist = (j + NUM_REQ - int'(last) - 1) % NUM_REQ;
                winner    = GRANT_W'(j);
            end
        end
    end

endmodule

// File: rtl/pio_access_arbiter.sv
// Round-robin arbiter serialising single-word transactions from several
// requesters onto one Avalon-MM PIO slave with registered read data.
// Optional build macro: PIO_ARB_LOCK_EN adds req_lock so a requester can hold
// the PIO across consecutive transactions (atomic read-modify-write).
module pio_access_arbiter
    import pio_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 3,
    parameter int DATA_W  = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         req_write,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_address,
    input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
`ifdef PIO_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]         req_lock,
`endif
    output logic [NUM_REQ-1:0]         ack,
    output logic [DATA_W-1:0]          rdata,
    output logic [GRANT_W-1:0]         grant_id,
    output logic [ADDR_W-1:0]          pio_address,
    output logic                       pio_chipselect,
    output logic                       pio_write_n,
    output logic [DATA_W-1:0]          pio_writedata,
    input  logic [DATA_W-1:0]          pio_readdata
);

    state_t               state;
    logic [NUM_REQ-1:0]   arb_req;
    logic [NUM_REQ-1:0]   grant_onehot;
    logic [GRANT_W-1:0]   pick_winner;
    logic                 pick_valid;
    logic                 sel_write;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_wdata;

    // One-hot form of the current grant, avoids indexing with a wider grant_id
    always_comb begin
        grant_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_onehot[i] = (int'(grant_id) == i);
        end
    end

`ifdef PIO_ARB_LOCK_EN
    logic lock_active;
    logic lock_hold;

    // Lock persists only while the owner keeps requesting
    assign lock_hold = lock_active && (|(req & grant_onehot));
    assign arb_req   = lock_hold ? (req & grant_onehot) : req;

    // Lock is taken from the owner's req_lock in its ACK cycle, dropped when it stops requesting
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_active <= 1'b0;
        end else if (state == S_ACK) begin
            lock_active <= |(req_lock & grant_onehot);
        end else if (state == S_IDLE && !lock_hold) begin
            lock_active <= 1'b0;
        end
    end
`else
    assign arb_req = req;
`endif

    pio_arb_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req    (arb_req),
        .last   (grant_id),
        .winner (pick_winner),
        .valid  (pick_valid)
    );

    // Select the winning requester's transaction fields from the flattened buses
    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (int'(pick_winner) == i) begin
                sel_write = req_write[i];
                sel_addr  = req_address[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Transaction sequencer with registered PIO strobes, ack and read data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            ack            <= '0;
            rdata          <= '0;
            grant_id       <= GRANT_W'(NUM_REQ - 1);
            pio_address    <= '0;
            pio_chipselect <= 1'b0;
            pio_write_n    <= 1'b1;
            pio_writedata  <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
            ack <= '0;
            case (state)
                S_IDLE: begin
                    if (pick_valid) begin
                        grant_id       <= pick_winner;
                        pio_address    <= sel_addr;
                        pio_writedata  <= sel_wdata;
                        pio_chipselect <= 1'b1;
                        pio_write_n    <= ~sel_write;
                        state          <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    pio_chipselect <= 1'b0;
                    pio_write_n    <= 1'b1;
                    if (!pio_write_n) begin
                        ack   <= grant_onehot;
                        state <= S_ACK;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    rdata <= pio_readdata;
                    ack   <= grant_onehot;
                    state <= S_ACK;
                end
                S_ACK: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pio_access_arbiter.sv
// Self-checking bench for pio_access_arbiter with a behavioural Avalon PIO
// (data, irq mask, set/clear aliases, registered readdata). Lock scenario is
// built when PIO_ARB_LOCK_EN is defined.
module tb_pio_access_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 3;
    localparam int DATA_W  = 32;

    logic                      clk;
    logic                      reset;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*ADDR_W-1:0] req_address;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
`ifdef PIO_ARB_LOCK_EN
    logic [NUM_REQ-1:0]        req_lock;
`endif
    logic [NUM_REQ-1:0]        ack;
    logic [DATA_W-1:0]         rdata;
    logic [2:0]                grant_id;
    logic [ADDR_W-1:0]         pio_address;
    logic                      pio_chipselect;
    logic                      pio_write_n;
    logic [DATA_W-1:0]         pio_writedata;
    logic [DATA_W-1:0]         pio_readdata;

    logic [DATA_W-1:0]         out_port;
    logic [DATA_W-1:0]         irq_mask;
    logic [DATA_W-1:0]         in_port;

    int checks   = 0;
    int failures = 0;

    int cs_double  = 0;
    int ack_bad    = 0;
    int ack_double = 0;
    logic prev_cs  = 1'b0;
    logic prev_ack = 1'b0;

    pio_access_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req            (req),
        .req_write      (req_write),
        .req_address    (req_address),
        .req_wdata      (req_wdata),
`ifdef PIO_ARB_LOCK_EN
        .req_lock       (req_lock),
`endif
        .ack            (ack),
        .rdata          (rdata),
        .grant_id       (grant_id),
        .pio_address    (pio_address),
        .pio_chipselect (pio_chipselect),
        .pio_write_n    (pio_write_n),
        .pio_writedata  (pio_writedata),
        .pio_readdata   (pio_readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural PIO slave
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            out_port     <= '0;
            irq_mask     <= '0;
            pio_readdata <= '0;
        end else begin
            if (pio_chipselect && !pio_write_n) begin
                case (pio_address)
                    3'd0: out_port <= pio_writedata;
                    3'd2: irq_mask <= pio_writedata;
                    3'd4: out_port <= out_port | pio_writedata;
                    3'd5: out_port <= out_port & ~pio_writedata;
                    default: ;
                endcase
            end
            pio_readdata <= (pio_address == 3'd0) ? in_port :
                            (pio_address == 3'd2) ? irq_mask : '0;
        end
    end

    // Protocol monitor: single-cycle chipselect, one-hot single-cycle ack
    always @(negedge clk) begin
        if (reset) begin
            prev_cs  <= 1'b0;
            prev_ack <= 1'b0;
        end else begin
            if (pio_chipselect && prev_cs) cs_double <= cs_double + 1;
            if (!$onehot0(ack))            ack_bad   <= ack_bad + 1;
            if ((|ack) && prev_ack)        ack_double <= ack_double + 1;
            prev_cs  <= pio_chipselect;
            prev_ack <= |ack;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_req(input int id, input logic wr, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d);
        req_write[id]                  = wr;
        req_address[id*ADDR_W +: ADDR_W] = a;
        req_wdata[id*DATA_W +: DATA_W]   = d;
        req[id]                        = 1'b1;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        req         = '0;
        req_write   = '0;
        req_address = '0;
        req_wdata   = '0;
`ifdef PIO_ARB_LOCK_EN
        req_lock    = '0;
`endif
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Wait (bounded) for a nonzero ack; lat counts negedges waited
    task automatic wait_ack(output logic [NUM_REQ-1:0] a, output int lat);
        a   = '0;
        lat = 0;
        while (lat < 20 && a == '0) begin
            @(negedge clk);
            lat++;
            a = ack;
        end
    endtask

    typedef struct {
        int                id;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] in_val;
        int                exp_lat;
        logic [DATA_W-1:0] exp_rdata;
        logic [DATA_W-1:0] exp_out;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [NUM_REQ-1:0] a;
        logic [NUM_REQ-1:0] oh;
        int                 lat;
        int                 cs_seen;
        logic [2:0]         order[6];

        vecs[0] = '{0, 1'b1, 3'd0, 32'hA5A5_0001, 32'h0,         2, 32'h0,         32'hA5A5_0001};
        vecs[1] = '{2, 1'b0, 3'd0, 32'h0,         32'h1234_5678, 3, 32'h1234_5678, 32'hA5A5_0001};
        vecs[2] = '{1, 1'b1, 3'd4, 32'h0000_00F0, 32'h0,         2, 32'h1234_5678, 32'hA5A5_00F1};
        vecs[3] = '{3, 1'b1, 3'd5, 32'hA5A5_0000, 32'h0,         2, 32'h1234_5678, 32'h0000_00F1};
        vecs[4] = '{3, 1'b0, 3'd0, 32'h0,         32'hDEAD_BEEF, 3, 32'hDEAD_BEEF, 32'h0000_00F1};
        vecs[5] = '{0, 1'b1, 3'd2, 32'h0000_0005, 32'h0,         2, 32'hDEAD_BEEF, 32'h0000_00F1};
        vecs[6] = '{1, 1'b0, 3'd2, 32'h0,         32'h0,         3, 32'h0000_0005, 32'h0000_00F1};

        in_port = '0;
        do_reset();

        // Reset values
        check("rst_ack",       32'(ack), 32'h0);
        check("rst_rdata",     rdata, 32'h0);
        check("rst_grant_id",  32'(grant_id), 32'(NUM_REQ - 1));
        check("rst_cs",        32'(pio_chipselect), 32'h0);
        check("rst_write_n",   32'(pio_write_n), 32'h1);
        check("rst_address",   32'(pio_address), 32'h0);
        check("rst_writedata", pio_writedata, 32'h0);

        // Table-driven single transactions
        for (int v = 0; v < 7; v++) begin
            in_port = vecs[v].in_val;
            @(negedge clk);
            set_req(vecs[v].id, vecs[v].wr, vecs[v].addr, vecs[v].wdata);
            lat     = 0;
            cs_seen = 0;
            a       = '0;
            while (lat < 20 && a == '0) begin
                @(negedge clk);
                lat++;
                if (pio_chipselect) cs_seen++;
                if (lat == 1) begin
                    check($sformatf("v%0d_issue_cs", v), 32'(pio_chipselect), 32'h1);
                    check($sformatf("v%0d_issue_wn", v), 32'(pio_write_n), 32'(!vecs[v].wr));
                    check($sformatf("v%0d_issue_addr", v), 32'(pio_address), 32'(vecs[v].addr));
                end
                if (lat == 2 && !vecs[v].wr) begin
                    check($sformatf("v%0d_wait_addr", v), 32'(pio_address), 32'(vecs[v].addr));
                end
                a = ack;
            end
            req[vecs[v].id] = 1'b0;
            oh = NUM_REQ'(1) << vecs[v].id;
            check($sformatf("v%0d_ack", v),      32'(a), 32'(oh));
            check($sformatf("v%0d_latency", v),  32'(lat), 32'(vecs[v].exp_lat));
            check($sformatf("v%0d_rdata", v),    rdata, vecs[v].exp_rdata);
            check($sformatf("v%0d_grant_id", v), 32'(grant_id), 32'(vecs[v].id));
            check($sformatf("v%0d_cs_count", v), 32'(cs_seen), 32'h1);
            @(negedge clk);
            check($sformatf("v%0d_out_port", v), out_port, vecs[v].exp_out);
            check($sformatf("v%0d_ack_cleared", v), 32'(ack), 32'h0);
        end

        // All four requesters writing continuously from reset
        do_reset();
        @(negedge clk);
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 3'd0, 32'(i + 1));
        for (int k = 0; k < 6; k++) begin
            wait_ack(a, lat);
            order[k] = 3'(grant_id);
            check($sformatf("fair_gap%0d", k), 32'(lat), (k == 0) ? 32'd2 : 32'd3);
            if (k == 5) req = '0;
        end
        check("fair_grant0", 32'(order[0]), 32'd0);
        check("fair_grant1", 32'(order[1]), 32'd1);
        check("fair_grant2", 32'(order[2]), 32'd2);
        check("fair_grant3", 32'(order[3]), 32'd3);
        check("fair_grant4", 32'(order[4]), 32'd0);
        check("fair_grant5", 32'(order[5]), 32'd1);
        @(negedge clk);
        check("fair_out_port", out_port, 32'h0000_0002);

        // Simultaneous SET from requester 1 and CLR from requester 3
        do_reset();
        @(negedge clk);
        set_req(1, 1'b1, 3'd4, 32'h0000_000F);
        set_req(3, 1'b1, 3'd5, 32'h0000_0003);
        wait_ack(a, lat);
        check("setclr_first_ack", 32'(a), 32'h2);
        req[1] = 1'b0;
        wait_ack(a, lat);
        check("setclr_second_ack", 32'(a), 32'h8);
        req[3] = 1'b0;
        @(negedge clk);
        check("setclr_out_port", out_port, 32'h0000_000C);

        // Reset asserted during WAIT of a read
        in_port = 32'h5555_AAAA;
        @(negedge clk);
        set_req(2, 1'b0, 3'd1, 32'h0);
        @(negedge clk);
        check("rstmid_issue_cs", 32'(pio_chipselect), 32'h1);
        @(negedge clk);
        check("rstmid_wait_addr", 32'(pio_address), 32'h1);
        reset = 1'b1;
        req   = '0;
        #1;
        check("rstmid_cs",       32'(pio_chipselect), 32'h0);
        check("rstmid_ack",      32'(ack), 32'h0);
        check("rstmid_grant_id", 32'(grant_id), 32'(NUM_REQ - 1));
        check("rstmid_address",  32'(pio_address), 32'h0);
        check("rstmid_write_n",  32'(pio_write_n), 32'h1);
        @(negedge clk);
        reset = 1'b0;
        lat = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (ack != '0) lat++;
        end
        check("rstmid_no_ack_after", 32'(lat), 32'h0);
        check("rstmid_rdata", rdata, 32'h0);

`ifdef PIO_ARB_LOCK_EN
        // Requester 0 performs a locked read then write while requester 1 waits
        do_reset();
        in_port = 32'h0000_00A0;
        @(negedge clk);
        set_req(0, 1'b0, 3'd0, 32'h0);
        req_lock[0] = 1'b1;
        set_req(1, 1'b1, 3'd0, 32'h0000_0011);
        wait_ack(a, lat);
        check("lock_first_ack", 32'(a), 32'h1);
        check("lock_first_rdata", rdata, 32'h0000_00A0);
        @(posedge clk);
        #1;
        set_req(0, 1'b1, 3'd0, 32'h0000_0022);
        req_lock[0] = 1'b0;
        wait_ack(a, lat);
        check("lock_second_ack", 32'(a), 32'h1);
        req[0] = 1'b0;
        @(negedge clk);
        check("lock_rmw_out_port", out_port, 32'h0000_0022);
        wait_ack(a, lat);
        check("lock_third_ack", 32'(a), 32'h2);
        req[1] = 1'b0;
        @(negedge clk);
        check("lock_final_out_port", out_port, 32'h0000_0011);
`endif

        repeat (2) @(negedge clk);
        check("mon_cs_single_cycle", 32'(cs_double), 32'h0);
        check("mon_ack_onehot",      32'(ack_bad), 32'h0);
        check("mon_ack_single",      32'(ack_double), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pio_access_arbiter.md
# pio_access_arbiter

Round-robin arbiter that shares one Avalon-MM PIO slave (3-bit word address, 32-bit data, registered readdata with one-cycle latency, set/clear aliases at addresses 4/5) among several on-chip requesters. It serialises single-word read and write transactions, holds the address through the read latency, and returns read data with a one-cycle acknowledge pulse. It sits between the requesting cores (CPU bridge, cartridge logic, debug port) and the PIO instance.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 3, PIO word-address width
- DATA_W, 32, data width
- clk  in  1  system clock, all logic rising-edge
- reset  in  1  asynchronous, active-high
- req  in  NUM_REQ  per-requester transaction request, level
- req_write  in  NUM_REQ  1 = write, 0 = read
- req_address  in  NUM_REQ*ADDR_W  flattened, requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  flattened, same packing
- ack  out  NUM_REQ  one-cycle completion pulse, one-hot or zero
- rdata  out  DATA_W  read result, valid while ack is high
- grant_id  out  3  index of current/last granted requester
- pio_address  out  ADDR_W  to PIO
- pio_chipselect  out  1  to PIO
- pio_write_n  out  1  to PIO, active-low
- pio_writedata  out  DATA_W  to PIO
- pio_readdata  in  DATA_W  from PIO, registered by PIO

## Operation
- States: IDLE, ISSUE, WAIT, ACK. Reset: IDLE, ack=0, rdata=0, grant_id=NUM_REQ-1, pio_chipselect=0, pio_write_n=1, pio_address=0, pio_writedata=0.
- IDLE: if any req, pick winner round-robin starting at grant_id+1 (wrapping modulo NUM_REQ); latch its write flag, address, wdata; grant_id<=winner; go ISSUE. No req: stay.
- ISSUE: exactly one cycle with pio_chipselect=1; pio_write_n=~write. Write -> ACK; read -> WAIT.
- WAIT: chipselect=0, pio_address held; pio_readdata captured into rdata at end of cycle; -> ACK.
- ACK: ack[grant_id]=1 for one cycle; -> IDLE.
- All pio_* outputs and ack/rdata are registered. pio_address and pio_writedata hold last value outside transactions.
- Requester rule: req and its fields stable from assertion until ack; req low in the cycle after ack, otherwise a new transaction is arbitrated (legal, treated as fresh request).
- Requests not granted stay pending without timeout; no request is dropped.
- Fairness: with all NUM_REQ requesting continuously, each gets exactly one transaction per NUM_REQ grants.
- rdata after a write is unchanged from previous read.
- Reset mid-operation: immediate return to reset values; in-flight transaction aborted, no ack issued.

## Timing
- Request high in cycle 0 (IDLE): ISSUE cycle 1, write ack cycle 2 (3 cycles/write).
- Read: ISSUE cycle 1, WAIT cycle 2, ack+rdata cycle 3 (4 cycles/read).
- Back-to-back: next IDLE evaluation in cycle after ACK; peak throughput one write per 3 cycles.
- req changes outside IDLE are ignored until next IDLE.

## Configuration
- PIO_ARB_LOCK_EN defined: adds input req_lock [NUM_REQ]. If granted requester's req_lock is high in its ACK cycle, the next IDLE considers only that requester (others wait) until it completes a transaction with req_lock low or drops req. Provides atomic read-modify-write of the PIO data register.
- Not defined: port absent, pure round-robin, lock logic removed.

## Structure
- Package pio_arb_pkg: state enum (IDLE, ISSUE, WAIT, ACK), PIO address constants (DATA=0, IRQ_MASK=2, SET=4, CLR=5), max NUM_REQ constant.
- One sub-module: pio_arb_rr_pick, combinational round-robin priority picker (req vector, last grant -> winner index, valid).

## Test plan
- Single write req[0], addr 0, data 0xA5A5_0001 -> chipselect pulse cycle 1 with write_n=0, ack[0] cycle 2, PIO out_port=0xA5A5_0001.
- Read req[2], addr 0, PIO in_port=0x1234_5678 -> ack[2] cycle 3, rdata=0x1234_5678, pio_address=0 during ISSUE and WAIT.
- All four requesters writing continuously from reset -> grant order 0,1,2,3,0,1; each ack one cycle, no chipselect overlap.
- Requester 1 writes SET addr 4 data 0x0F, requester 3 writes CLR addr 5 data 0x03 simultaneously, out_port 0 -> grant 1 then 3, final out_port 0x0C.
- reset asserted during WAIT -> same-cycle chipselect=0, ack=0, state IDLE, grant_id=NUM_REQ-1; no ack after release.
- With PIO_ARB_LOCK_EN: req 0 locked read+write of addr 0 while req 1 pending -> req 1 granted only after req 0's unlocked write acks.
